// File: rtl/display_page_scheduler_if.sv
// rtl/display_page_scheduler_if.sv - vehicle-state inputs and page outputs of the display scheduler
interface display_page_scheduler_if;
    logic        tick;
    logic        obd_mode_sw;
    logic        ack;
    logic [13:0] rpm;
    logic [7:0]  fuel;
    logic [7:0]  temp;
    logic [2:0]  page;
    logic        blank;
    logic [2:0]  warn_act;

    modport master (
        output tick, obd_mode_sw, ack, rpm, fuel, temp,
        input  page, blank, warn_act
    );

    modport slave (
        input  tick, obd_mode_sw, ack, rpm, fuel, temp,
        output page, blank, warn_act
    );
endinterface

// File: rtl/display_page_scheduler.sv
// rtl/display_page_scheduler.sv - chooses gauge, mode banner or blinking warning page for the dashboard
module display_page_scheduler #(
    parameter int DEB_TICKS    = 10,
    parameter int SHOW_TICKS   = 200,
    parameter int GAP_TICKS    = 300,
    parameter int BANNER_TICKS = 100,
    parameter int BLINK_TICKS  = 25,
    parameter int FUEL_LOW_TH  = 10,
    parameter int TEMP_HI_TH   = 110,
    parameter int RPM_RED_TH   = 6500
) (
    input logic                     clk,
    input logic                     rst,
    display_page_scheduler_if.slave bus
);
    typedef enum logic [1:0] {S_GAUGE, S_BANNER, S_WARN, S_GAP} state_t;

    state_t      state, state_n;
    logic [1:0]  cur, cur_n, last_shown, last_n;
    logic [15:0] timer, timer_n, bcnt, bcnt_n;
    logic        phase, phase_n;
    logic [2:0]  warn_q, acked, raw, pending;
    logic [7:0]  deb_cnt [3];
    logic        mode_q, armed, mode_edge;
    logic [2:0]  page_q;
    logic        blank_q;

    assign raw = {bus.rpm >= 14'(RPM_RED_TH), bus.temp >= 8'(TEMP_HI_TH), bus.fuel < 8'(FUEL_LOW_TH)};
    assign pending   = warn_q & ~acked;
    assign mode_edge = armed && (mode_q != bus.obd_mode_sw);

    assign bus.page     = page_q;
    assign bus.blank    = blank_q;
    assign bus.warn_act = warn_q;

    // Cyclic order FUEL(0) -> TEMP(1) -> RPM(2) -> FUEL, starting after the given index
    function automatic logic [1:0] pick_next(input logic [1:0] after, input logic [2:0] p);
        logic [1:0] r;
        case (after)
            2'd0:    r = p[1] ? 2'd1 : (p[2] ? 2'd2 : 2'd0);
            2'd1:    r = p[2] ? 2'd2 : (p[0] ? 2'd0 : 2'd1);
            default: r = p[0] ? 2'd0 : (p[1] ? 2'd1 : 2'd2);
        endcase
        return r;
    endfunction

    function automatic logic [2:0] page_of(input state_t s, input logic [1:0] c);
        logic [2:0] r;
        case (s)
            S_BANNER: r = 3'd1;
            S_WARN:   r = 3'd2 + {1'b0, c};
            default:  r = 3'd0;
        endcase
        return r;
    endfunction

    // A stale ack bit after its warning falls is harmless: pending is masked by warn_q anyway
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warn_q <= '0;
            acked  <= '0;
            mode_q <= 1'b0;
            armed  <= 1'b0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            mode_q <= bus.obd_mode_sw;
            armed  <= 1'b1;
            acked  <= (acked | {3{bus.ack}}) & warn_q;
            if (bus.tick) begin
                for (int i = 0; i < 3; i++) begin
                    if (raw[i] == warn_q[i]) begin
                        deb_cnt[i] <= '0;
                    end else if (deb_cnt[i] == 8'(DEB_TICKS - 1)) begin
                        deb_cnt[i] <= '0;
                        warn_q[i]  <= ~warn_q[i];
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        cur_n   = cur;
        last_n  = last_shown;
        timer_n = timer;
        bcnt_n  = bcnt;
        phase_n = phase;
        if (bus.tick && timer != 16'd0) timer_n = timer - 16'd1;
        if (state == S_WARN && bus.tick) begin
            if (bcnt == 16'(BLINK_TICKS - 1)) begin
                bcnt_n  = 16'd0;
                phase_n = ~phase;
            end else begin
                bcnt_n = bcnt + 16'd1;
            end
        end
        if (mode_edge) begin
            state_n = S_BANNER;
            timer_n = 16'(BANNER_TICKS);
        end else begin
            case (state)
                S_GAUGE: if (pending != 3'b000) begin
                    state_n = S_WARN;
                    cur_n   = pick_next(last_shown, pending);
                    timer_n = 16'(SHOW_TICKS);
                    bcnt_n  = 16'd0;
                    phase_n = 1'b0;
                end
                S_BANNER: if (bus.tick && timer <= 16'd1) begin
                    if (pending != 3'b000) begin
                        state_n = S_GAP;
                        timer_n = 16'(GAP_TICKS);
                    end else begin
                        state_n = S_GAUGE;
                    end
                end
                S_WARN: begin
                    if (bus.ack) begin
                        state_n = S_GAUGE;
                    end else if (!pending[cur]) begin
                        if (pending == 3'b000) begin
                            state_n = S_GAUGE;
                        end else begin
                            cur_n   = pick_next(cur, pending);
                            timer_n = 16'(SHOW_TICKS);
                            bcnt_n  = 16'd0;
                            phase_n = 1'b0;
                        end
                    end else if (bus.tick && timer <= 16'd1) begin
                        state_n = S_GAP;
                        timer_n = 16'(GAP_TICKS);
                        last_n  = cur;
                    end
                end
                default: if (pending == 3'b000 || (bus.tick && timer <= 16'd1)) state_n = S_GAUGE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_GAUGE;
            cur        <= 2'd0;
            last_shown <= 2'd2;
            timer      <= '0;
            bcnt       <= '0;
            phase      <= 1'b0;
            page_q     <= 3'd0;
            blank_q    <= 1'b0;
        end else begin
            state      <= state_n;
            cur        <= cur_n;
            last_shown <= last_n;
            timer      <= timer_n;
            bcnt       <= bcnt_n;
            phase      <= phase_n;
            page_q     <= page_of(state_n, cur_n);
            blank_q    <= (state_n == S_WARN) && phase_n;
        end
    end
endmodule

// File: tb/tb_display_page_scheduler.sv
// tb/tb_display_page_scheduler.sv - bench for display_page_scheduler
module tb_display_page_scheduler;
    localparam int DEB = 10, SHOW = 200, GAP = 300, BANNER = 100, BLINK = 25;
    localparam int FUEL_TH = 10, TEMP_TH = 110, RPM_TH = 6500;
    localparam int M_GAUGE = 0, M_BANNER = 1, M_WARN = 2, M_GAP = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    display_page_scheduler_if bus();

    display_page_scheduler #(
        .DEB_TICKS(DEB), .SHOW_TICKS(SHOW), .GAP_TICKS(GAP), .BANNER_TICKS(BANNER),
        .BLINK_TICKS(BLINK), .FUEL_LOW_TH(FUEL_TH), .TEMP_HI_TH(TEMP_TH), .RPM_RED_TH(RPM_TH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int       m_st, m_left, m_in, m_cur, m_last;
    int       m_run [3];
    bit [2:0] m_wact, m_acked;
    bit       m_armed, m_mode;

    task automatic m_reset();
        m_st = M_GAUGE; m_left = 0; m_in = 0; m_cur = 0; m_last = 2;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
        m_wact = 3'b000; m_acked = 3'b000; m_armed = 1'b0; m_mode = 1'b0;
    endtask

    function automatic int first_after(input int x, input bit [2:0] p);
        for (int k = 1; k <= 3; k++) begin
            int j;
            j = (x + k) % 3;
            if (p[j]) return j;
        end
        return x;
    endfunction

    task automatic model_clk(input bit t, input bit md, input bit ak, input int r, input int f, input int tp);
        bit [2:0] raw, pend, nw;
        bit       ed;
        raw[0] = f < FUEL_TH;
        raw[1] = tp >= TEMP_TH;
        raw[2] = r >= RPM_TH;
        pend = m_wact & ~m_acked;
        ed = m_armed && (m_mode != md);
        m_mode = md;
        m_armed = 1'b1;
        if (ed) begin
            m_st = M_BANNER; m_left = BANNER;
        end else if (m_st == M_GAUGE) begin
            if (pend != 0) begin m_st = M_WARN; m_cur = first_after(m_last, pend); m_in = 0; end
        end else if (m_st == M_BANNER) begin
            if (t) begin
                m_left--;
                if (m_left == 0) begin
                    if (pend != 0) begin m_st = M_GAP; m_left = GAP; end
                    else m_st = M_GAUGE;
                end
            end
        end else if (m_st == M_WARN) begin
            if (ak) m_st = M_GAUGE;
            else if (!pend[m_cur]) begin
                if (pend == 0) m_st = M_GAUGE;
                else begin m_cur = first_after(m_cur, pend); m_in = 0; end
            end else if (t) begin
                m_in++;
                if (m_in == SHOW) begin m_last = m_cur; m_st = M_GAP; m_left = GAP; end
            end
        end else begin
            if (pend == 0) m_st = M_GAUGE;
            else if (t) begin m_left--; if (m_left == 0) m_st = M_GAUGE; end
        end
        nw = m_wact;
        if (t) begin
            for (int i = 0; i < 3; i++) begin
                if (raw[i] != m_wact[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin nw[i] = ~nw[i]; m_run[i] = 0; end
                end else m_run[i] = 0;
            end
        end
        if (ak) m_acked = m_acked | m_wact;
        m_acked = m_acked & nw;
        m_wact = nw;
    endtask

    function automatic logic [6:0] want_vec();
        logic [2:0] p;
        logic       b;
        p = (m_st == M_WARN) ? 3'(2 + m_cur) : ((m_st == M_BANNER) ? 3'd1 : 3'd0);
        b = (m_st == M_WARN) && ((m_in / BLINK) % 2 == 1);
        return {p, b, m_wact};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {bus.page, bus.blank, bus.warn_act};
    endfunction

    task automatic cyc(input bit t);
        bus.tick = t;
        @(posedge clk);
        if (rst) m_reset();
        else model_clk(t, bus.obd_mode_sw, bus.ack, int'(bus.rpm), int'(bus.fuel), int'(bus.temp));
        #1;
        bus.tick = 1'b0;
        bus.ack  = 1'b0;
    endtask

    task automatic tk();
        cyc(1'b1);
        cyc(1'b0);
    endtask

    task automatic run_while(input logic [2:0] p, input int limit, output int n, output int mm);
        n = 0; mm = 0;
        while (bus.page == p && n < limit) begin
            cyc(1'b1);
            if (dut_vec() !== want_vec()) mm++;
            cyc(1'b0);
            if (dut_vec() !== want_vec()) mm++;
            n++;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        total++; if (dut_vec() !== 7'd0) begin bad++; $display("FAIL reset_state got=%h want=00", dut_vec()); end
        repeat (3) cyc(1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0);
            total++; if (dut_vec() !== 7'd0) begin bad++; $display("FAIL reset_release_no_banner got=%h want=00", dut_vec()); end
        end
    endtask

    task automatic test_banner();
        int n, mm;
        bus.obd_mode_sw = 1'b0;
        cyc(1'b0);
        total++; if (bus.page !== 3'd1) begin bad++; $display("FAIL banner_enter got=%0d want=1", bus.page); end
        run_while(3'd1, 300, n, mm);
        total++; if (n !== BANNER) begin bad++; $display("FAIL banner_len got=%0d want=%0d", n, BANNER); end
        total++; if (mm !== 0) begin bad++; $display("FAIL banner_model got=%0d want=0", mm); end
        total++; if (bus.page !== 3'd0) begin bad++; $display("FAIL banner_exit got=%0d want=0", bus.page); end
    endtask

    task automatic test_debounce();
        int n, mm;
        bus.fuel = 8'd5;
        repeat (9) tk();
        bus.fuel = 8'd50;
        tk();
        total++; if (bus.warn_act !== 3'b000) begin bad++; $display("FAIL deb_nine_ticks got=%b want=000", bus.warn_act); end
        repeat (3) tk();
        bus.fuel = 8'd5;
        repeat (9) tk();
        total++; if (bus.warn_act !== 3'b000) begin bad++; $display("FAIL deb_not_yet got=%b want=000", bus.warn_act); end
        cyc(1'b1);
        total++; if ({bus.warn_act, bus.page} !== {3'b001, 3'd0}) begin bad++; $display("FAIL deb_set got=%b/%0d want=001/0", bus.warn_act, bus.page); end
        cyc(1'b0);
        total++; if ({bus.page, bus.blank} !== {3'd2, 1'b0}) begin bad++; $display("FAIL warn_enter got=%0d/%b want=2/0", bus.page, bus.blank); end
        run_while(3'd2, 400, n, mm);
        total++; if (n !== SHOW) begin bad++; $display("FAIL show_len got=%0d want=%0d", n, SHOW); end
        total++; if (mm !== 0) begin bad++; $display("FAIL fuel_blink_model got=%0d want=0", mm); end
    endtask

    task automatic test_round_robin();
        int n, mm;
        int exp_p [5] = '{0, 3, 0, 2, 0};
        int exp_n [5] = '{GAP, SHOW, GAP, SHOW, GAP};
        bus.temp = 8'd120;
        for (int k = 0; k < 5; k++) begin
            run_while(3'(exp_p[k]), 1000, n, mm);
            total++; if (n !== exp_n[k]) begin bad++; $display("FAIL rr_len step=%0d page=%0d got=%0d want=%0d", k, exp_p[k], n, exp_n[k]); end
            total++; if (mm !== 0) begin bad++; $display("FAIL rr_model step=%0d got=%0d want=0", k, mm); end
        end
        total++; if (bus.page !== 3'd3) begin bad++; $display("FAIL rr_wrap got=%0d want=3", bus.page); end
    endtask

    task automatic test_ack();
        int n, mm;
        bus.ack = 1'b1;
        cyc(1'b0);
        total++; if ({bus.page, bus.warn_act} !== {3'd0, 3'b011}) begin bad++; $display("FAIL ack_exit got=%0d/%b want=0/011", bus.page, bus.warn_act); end
        run_while(3'd0, 50, n, mm);
        total++; if (n !== 50 || mm !== 0) begin bad++; $display("FAIL ack_hold got=%0d/%0d want=50/0", n, mm); end
        bus.temp = 8'd100;
        run_while(3'd0, 10, n, mm);
        total++; if (bus.warn_act !== 3'b001) begin bad++; $display("FAIL ack_temp_clear got=%b want=001", bus.warn_act); end
        bus.temp = 8'd110;
        run_while(3'd0, 10, n, mm);
        total++; if ({bus.page, bus.warn_act} !== {3'd3, 3'b011} || mm !== 0) begin bad++; $display("FAIL ack_temp_return got=%0d/%b want=3/011", bus.page, bus.warn_act); end
    endtask

    task automatic test_mode_during_warn();
        int n, mm;
        bus.temp = 8'd90;
        bus.rpm  = 14'd7000;
        run_while(3'd3, 10, n, mm);
        total++; if ({bus.page, bus.warn_act} !== {3'd4, 3'b101} || mm !== 0) begin bad++; $display("FAIL reselect_rpm got=%0d/%b want=4/101", bus.page, bus.warn_act); end
        repeat (30) tk();
        bus.obd_mode_sw = ~bus.obd_mode_sw;
        cyc(1'b0);
        total++; if (bus.page !== 3'd1) begin bad++; $display("FAIL warn_banner got=%0d want=1", bus.page); end
        run_while(3'd1, 300, n, mm);
        total++; if (n !== BANNER || mm !== 0) begin bad++; $display("FAIL warn_banner_len got=%0d/%0d want=%0d/0", n, mm, BANNER); end
        run_while(3'd0, 600, n, mm);
        total++; if (n !== GAP || mm !== 0) begin bad++; $display("FAIL banner_gap_len got=%0d/%0d want=%0d/0", n, mm, GAP); end
        total++; if (bus.page !== 3'd4) begin bad++; $display("FAIL gap_to_rpm got=%0d want=4", bus.page); end
    endtask

    task automatic test_reset_mid();
        repeat (30) tk();
        total++; if ({bus.page, bus.blank} !== {3'd4, 1'b1}) begin bad++; $display("FAIL pre_reset_blank got=%0d/%b want=4/1", bus.page, bus.blank); end
        #2 rst = 1'b1;
        #1;
        total++; if (dut_vec() !== 7'd0) begin bad++; $display("FAIL async_reset got=%h want=00", dut_vec()); end
        repeat (2) cyc(1'b0);
        rst = 1'b0;
    endtask

    task automatic test_thresholds();
        int n, mm;
        bus.fuel = 8'd10; bus.temp = 8'd109; bus.rpm = 14'd6499;
        run_while(3'd0, 12, n, mm);
        total++; if (bus.warn_act !== 3'b000 || mm !== 0) begin bad++; $display("FAIL below_threshold got=%b want=000", bus.warn_act); end
        bus.fuel = 8'd9; bus.temp = 8'd110; bus.rpm = 14'd6500;
        repeat (10) tk();
        total++; if ({bus.warn_act, bus.page} !== {3'b111, 3'd2}) begin bad++; $display("FAIL at_threshold got=%b/%0d want=111/2", bus.warn_act, bus.page); end
    endtask

    task automatic test_random();
        int fl, tp, rp;
        fl = 12; tp = 105; rp = 6450;
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 39) == 0) fl = $urandom_range(5, 15);
            if ($urandom_range(0, 39) == 0) tp = $urandom_range(105, 115);
            if ($urandom_range(0, 39) == 0) rp = $urandom_range(6450, 6550);
            bus.fuel = 8'(fl);
            bus.temp = 8'(tp);
            bus.rpm  = 14'(rp);
            bus.ack  = ($urandom_range(0, 150) == 0);
            if ($urandom_range(0, 699) == 0) bus.obd_mode_sw = ~bus.obd_mode_sw;
            cyc($urandom_range(0, 1) == 1);
            total++;
            if (dut_vec() !== want_vec()) begin
                bad++;
                $display("FAIL random_model cycle=%0d got=%h want=%h", c, dut_vec(), want_vec());
            end
        end
    endtask

    initial begin
        bus.tick = 1'b0; bus.ack = 1'b0; bus.obd_mode_sw = 1'b1;
        bus.rpm = 14'd1000; bus.fuel = 8'd50; bus.temp = 8'd90;
        m_reset();
        test_reset();
        test_banner();
        test_debounce();
        test_round_robin();
        test_ack();
        test_mode_during_warn();
        test_reset_mid();
        test_thresholds();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/display_page_scheduler.md
Name: display_page_scheduler

Overview:
- Decides what the 8-digit dashboard display shows each moment: normal gauge page, a mode-change banner, or one of three blinking warning pages.
- Sits between the vehicle-state registers (rpm, fuel, temp) and the display datapath. Drives a page code and blank strobe; the datapath renders the page.
- Debounces warning conditions, round-robins between pending warnings with a gauge gap in between, and supports a driver acknowledge.

Parameters:
- DEB_TICKS, 10: consecutive ticks a condition must hold (or be absent) to set (or clear) a warning.
- SHOW_TICKS, 200: ticks one warning page is shown.
- GAP_TICKS, 300: ticks the gauge page is shown between warning pages.
- BANNER_TICKS, 100: ticks the mode banner is shown.
- BLINK_TICKS, 25: half-period of the warning blink, in ticks.
- FUEL_LOW_TH, 10: fuel below this value raises the low-fuel condition.
- TEMP_HI_TH, 110: temp at or above this value raises the over-temperature condition.
- RPM_RED_TH, 6500: rpm at or above this value raises the over-rev condition.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-clk pulse every 10 ms; all timers advance only on tick.
- obd_mode_sw  in  1  synchronized mode switch (0 Normal, 1 OBD).
- ack  in  1  one-clk acknowledge pulse from the debounced driver button.
- rpm  in  14  engine rpm.
- fuel  in  8  fuel level.
- temp  in  8  engine temperature.
- page  out  3  page code: 0 GAUGE, 1 BANNER, 2 FUEL, 3 TEMP, 4 RPM.
- blank  out  1  1 = display datapath must blank all digits.
- warn_act  out  3  debounced active warnings: [0] FUEL, [1] TEMP, [2] RPM.

Behaviour:
- Reset: page=0, blank=0, warn_act=0; all counters 0; ack bits 0; state GAUGE; banner disarmed.
- Debounce, per warning:
  - Counter counts ticks where the raw condition differs from warn_act[i], and resets to 0 on any tick where it matches.
  - When the counter reaches DEB_TICKS, warn_act[i] toggles and the counter clears.
  - Raw compares are unsigned and full width.
- Ack bits:
  - An ack pulse sets acked[i] for every i where warn_act[i]=1.
  - acked[i] clears when warn_act[i] falls.
  - pending = warn_act & ~acked.
- Banner edge detect:
  - mode_q is loaded every clk. The first clk after reset release only loads it (arming); no edge is reported.
  - An armed mode_q != obd_mode_sw is an edge.
- State machine, states GAUGE, BANNER, WARN, GAP, all registered:
  - page reflects the new state on the clk after the deciding input is sampled.
  - Any state, on an edge: go to BANNER and load the banner timer with BANNER_TICKS. A re-toggle during BANNER reloads the timer. An edge outranks all other transitions that cycle.
  - BANNER, timer reaches 0: go to GAP if pending != 0, else GAUGE.
  - GAUGE, pending != 0: go to WARN. The selected warning is the first pending one after last_shown in cyclic order FUEL→TEMP→RPM→FUEL (last_shown resets to RPM, so FUEL goes first). Load the show timer with SHOW_TICKS and clear the blink phase.
  - WARN, show timer reaches 0: go to GAP and load the gap timer with GAP_TICKS; last_shown = current.
  - WARN, shown warning leaves pending: re-select the next pending warning and reload SHOW_TICKS. If none remain, go to GAUGE.
  - WARN, ack: go to GAUGE on the same cycle the ack bits set. No warning re-enters until a new pending bit appears.
  - GAP, gap timer reaches 0: go to GAUGE. GAUGE re-enters WARN on the next clk if pending.
  - GAP, pending becomes 0: go to GAUGE immediately.
- page values: GAUGE→0, GAP→0, BANNER→1, WARN→2/3/4 for FUEL/TEMP/RPM.
- Blink:
  - In WARN, the blink phase toggles every BLINK_TICKS ticks, starting visible.
  - blank = 1 only in WARN during the off phase; blank = 0 in every other state.
- Timers decrement only on tick and saturate at 0.
- Reset mid-operation returns to the reset values immediately (asynchronous).

Test Plan:
- Reset release with obd_mode_sw=1 held: page stays 0, no BANNER; a later toggle to 0 gives page=1 for exactly 100 ticks, then 0.
- fuel=5 held for 9 ticks then fuel=50: warn_act stays 0. fuel=5 held for 10 ticks: warn_act[0]=1, page=2 next clk, blank toggles every 25 ticks starting 0, page=0 after 200 ticks.
- FUEL and TEMP both pending: page sequence 2 (200 ticks), 0 (300 ticks), 3 (200 ticks), 0 (300 ticks), 2 …
- ack while page=3: page=0 next clk and stays 0. temp drops below 110 for 10 ticks, then rises ≥110 for 10 ticks: page=3 again.
- Mode toggle during WARN with rpm=7000: page=1 for 100 ticks, then GAP (page 0, 300 ticks), then page=4.
- rst asserted mid-WARN: page=0, blank=0, warn_act=0 without waiting for clk.
